// File: rtl/mem_pkg.sv
// Shared state encoding, default geometry and address-offset helper for the burst buffer.
// Pure declarations: no latency, no flow control.
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DEF_BUS_W  = 32;
    localparam int DEF_BEATS  = 4;
    localparam int DEF_TO_CYC = 255;

    // Number of byte-offset bits inside one cache line.
    function automatic int calc_off(input int bus_w, input int beats);
        return $clog2(beats * bus_w / 8);
    endfunction

endpackage

// File: rtl/mem_burst_buffer_if.sv
// Line-side request/response and beat-side bus signals of the burst buffer.
// slave = the buffer itself, master = the requester plus memory model driving it.
interface mem_burst_buffer_if
    import mem_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W,
    parameter int BEATS = DEF_BEATS
);
    logic                   mem_r;
    logic                   mem_w;
    logic                   mem_wb;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wb_addr;
    logic [BEATS*BUS_W-1:0] mem_wdata;
    logic [BEATS*BUS_W-1:0] mem_rdata;
    logic                   ready;
    logic                   err;
    logic                   busy;
    logic                   bus_r;
    logic                   bus_w;
    logic [31:0]            bus_addr;
    logic [BUS_W-1:0]       bus_wdata;
    logic [BUS_W-1:0]       bus_rdata;
    logic                   bus_ready;

    modport slave (
        input  mem_r, mem_w, mem_wb, mem_addr, mem_wb_addr, mem_wdata, bus_rdata, bus_ready,
        output mem_rdata, ready, err, busy, bus_r, bus_w, bus_addr, bus_wdata
    );

    modport master (
        output mem_r, mem_w, mem_wb, mem_addr, mem_wb_addr, mem_wdata, bus_rdata, bus_ready,
        input  mem_rdata, ready, err, busy, bus_r, bus_w, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_burst_buffer_burst_timer.sv
// Per-beat stall counter; expired fires combinationally on the stall cycle that reaches TO_CYC.
// No flow control: run counts, clr wins over run.
module burst_timer #(
    parameter int TO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == 16'(TO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (run) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_burst_buffer.sv
// Line <-> beat burst engine: read, write, or writeback-then-refill of one cache line.
// Latency BEATS+1 (2*BEATS+1 for writeback) with zero-wait bus; stalls on bus_ready, aborts after TO_CYC.
module mem_burst_buffer
    import mem_pkg::*;
#(
    parameter int BUS_W  = DEF_BUS_W,
    parameter int BEATS  = DEF_BEATS,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input logic              clk,
    input logic              rst_n,
    mem_burst_buffer_if.slave bif
);
    localparam int          LINE_W    = BEATS * BUS_W;
    localparam int          OFF       = calc_off(BUS_W, BEATS);
    localparam int          BEAT_BITS = $clog2(BEATS);
    localparam int          BYTE_BITS = $clog2(BUS_W / 8);
    localparam logic [31:0] LINE_MASK = 32'((64'd1 << OFF) - 64'd1);

    logic [1:0]           state_q, state_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic                 op_wb_q, op_wb_d;
    logic                 err_q, err_d;
    logic [31:0]          addr_q, addr_d, wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]    wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic                 strobe, adv, last, accept, expired;
    logic [31:0]          line_addr;
    logic [BUS_W-1:0]     wr_word;

    assign strobe = (state_q == ST_WR) || (state_q == ST_RD);
    assign adv    = strobe && bif.bus_ready;
    assign last   = (beat_q == BEAT_BITS'(BEATS - 1));
    assign accept = (state_q == ST_IDLE) && (bif.mem_r || bif.mem_w || bif.mem_wb);

    burst_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (strobe && !bif.bus_ready),
        .clr     (accept || adv || expired),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        op_wb_d   = op_wb_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wb_addr_d = wb_addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = bif.mem_addr;
                    wb_addr_d = bif.mem_wb_addr;
                    wdata_d   = bif.mem_wdata;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    op_wb_d   = bif.mem_wb;
                    state_d   = (bif.mem_wb || bif.mem_w) ? ST_WR : ST_RD;
                end
            end
            ST_WR, ST_RD: begin
                if (adv) begin
                    if (state_q == ST_RD) begin
                        for (int k = 0; k < BEATS; k++)
                            if (beat_q == BEAT_BITS'(k)) rbuf_d[k*BUS_W +: BUS_W] = bif.bus_rdata;
                    end
                    beat_d = beat_q + BEAT_BITS'(1);
                    if (last) state_d = (state_q == ST_WR && op_wb_q) ? ST_RD : ST_DONE;
                end else if (expired) begin
                    // Abort drops every remaining beat, including a pending refill phase.
                    beat_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            op_wb_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            op_wb_q   <= op_wb_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
        end
    end

    always_comb begin
        wr_word = '0;
        for (int k = 0; k < BEATS; k++)
            if (beat_q == BEAT_BITS'(k)) wr_word = wdata_q[k*BUS_W +: BUS_W];
    end

    assign line_addr     = (state_q == ST_WR && op_wb_q) ? wb_addr_q : addr_q;
    assign bif.bus_w     = (state_q == ST_WR);
    assign bif.bus_r     = (state_q == ST_RD);
    assign bif.bus_addr  = strobe ? ((line_addr & ~LINE_MASK) | (32'(beat_q) << BYTE_BITS)) : 32'd0;
    assign bif.bus_wdata = (state_q == ST_WR) ? wr_word : '0;
    assign bif.mem_rdata = rbuf_q;
    assign bif.ready     = (state_q == ST_DONE);
    assign bif.err       = err_q;
    assign bif.busy      = (state_q != ST_IDLE);
endmodule

// File: doc/mem_burst_buffer.md
MEM_BURST_BUFFER -- requirements
Module: mem_burst_buffer

Interface
REQ-001 Parameter BUS_W, default 32, bus data width in bits (power of two, at least 8).
REQ-002 Parameter BEATS, default 4, bus beats per line (power of two, 2..16).
REQ-003 Parameter TO_CYC, default 255, maximum wait cycles per beat before timeout (1..65535).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 mem_r  in  1  line read (refill) request.
REQ-007 mem_w  in  1  line write request.
REQ-008 mem_wb  in  1  writeback-then-refill request: write line to mem_wb_addr, then read line from mem_addr.
REQ-009 mem_addr  in  32  read/write line address; offset bits ignored.
REQ-010 mem_wb_addr  in  32  writeback line address (mem_wb only).
REQ-011 mem_wdata  in  BEATS*BUS_W  line to write; beat k is bits [k*BUS_W +: BUS_W].
REQ-012 mem_rdata  out  BEATS*BUS_W  line read; same beat ordering.
REQ-013 ready  out  1  one-cycle completion pulse.
REQ-014 err  out  1  valid with ready; 1 = transaction aborted on timeout.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 bus_r / bus_w  out  1  bus read / write strobe.
REQ-017 bus_addr  out  32  beat byte address.
REQ-018 bus_wdata  out  BUS_W  beat write data.
REQ-019 bus_rdata  in  BUS_W  beat read data.
REQ-020 bus_ready  in  1  current beat completes this cycle.

Function
REQ-021 States IDLE, WR, RD, DONE; IDLE leaves only on a request; DONE always returns to IDLE after one cycle.
REQ-022 Requests are sampled only in IDLE; priority mem_wb > mem_w > mem_r; request inputs in other states are ignored and not queued.
REQ-023 On acceptance: mem_wdata, mem_addr and mem_wb_addr are latched, beat counter = 0, timeout counter = 0, err flag cleared.
REQ-024 Transitions: IDLE to WR on mem_wb or mem_w; IDLE to RD on mem_r; WR to RD after last beat when the op is mem_wb; WR to DONE after last beat when the op is mem_w; RD to DONE after last beat.
REQ-025 bus_addr = {line address[31:OFF], beat[log2 BEATS-1:0], zeros[log2(BUS_W/8)-1:0]}, OFF = log2(BEATS*BUS_W/8); WR in mem_wb mode uses the latched mem_wb_addr, all other beats use the latched mem_addr.
REQ-026 Strobes are combinational from state: bus_w=1 only in WR, bus_r=1 only in RD, never both; both 0 in IDLE/DONE; bus_addr and bus_wdata are 0 in those states.
REQ-027 Beat advances on a cycle with strobe and bus_ready high; the counter wraps to 0 on the last beat (BEATS-1) when the state changes.
REQ-028 In RD, bus_rdata is written into beat[counter] of the read buffer on the cycle bus_ready=1; the other beats hold.
REQ-029 mem_rdata is the read buffer; it is stable from DONE until the next RD beat captures data; a mem_w transaction does not alter it.
REQ-030 The timeout counter increments on each strobe cycle with bus_ready=0 and clears on beat advance.
REQ-031 When the counter reaches TO_CYC with bus_ready still 0: abandon the remaining beats, including the RD phase of mem_wb; set err; go to DONE; the read buffer keeps beats already captured.
REQ-032 bus_ready and timeout in the same cycle: bus_ready wins and the beat completes normally.
REQ-033 ready=1 exactly in DONE; err is registered, equals the abort flag in DONE and is 0 elsewhere.
REQ-034 Latency with zero-wait bus: mem_r/mem_w give ready BEATS+1 cycles after acceptance; mem_wb gives 2*BEATS+1.
REQ-035 bus_ready in IDLE/DONE has no effect.

Reset
REQ-036 While rst_n=0: state IDLE, counters 0, err 0, read buffer 0, latched addresses and data 0; hence ready, busy, bus_r, bus_w = 0 and bus_addr, bus_wdata, mem_rdata = 0.
REQ-037 Reset mid-transaction aborts immediately with no ready pulse; the first edge after rst_n rises stays in IDLE unless a request is present.

Structure
REQ-038 Shared package mem_pkg holds the state encoding (2-bit), default BUS_W/BEATS/TO_CYC constants and the OFF computation function.
REQ-039 One sub-module, burst_timer (timeout counter; inputs run, clr; output expired), is instantiated once; everything else is in mem_burst_buffer.

Verification
REQ-040 BEATS=4, mem_r at 0x0000_1234, bus_ready=1 always, bus_rdata=0xA0+beat -> bus_addr 0x1230,0x1234,0x1238,0x123C; ready on cycle 5; mem_rdata=0x000000A3_000000A2_000000A1_000000A0; err=0.
REQ-041 mem_w at 0x40 with wdata words W3..W0, bus_ready low 2 cycles per beat -> bus_wdata W0..W3 in order at 0x40..0x4C; ready after 13 cycles; mem_rdata unchanged.
REQ-042 mem_wb, wb_addr 0x100, addr 0x200 -> four writes to 0x100..0x10C, then four reads from 0x200..0x20C; one ready pulse after 9 cycles.
REQ-043 TO_CYC=3, mem_r, bus_ready stuck 0 at beat 2 -> strobe held exactly 3 cycles, then DONE with ready=1, err=1; beats 0-1 captured, beats 2-3 keep old values.
REQ-044 rst_n pulsed low during RW beat 1 of mem_wb -> all outputs 0 asynchronously, no ready; new mem_r afterwards completes normally.
REQ-045 mem_r and mem_w asserted together, then mem_r asserted while busy -> write executes alone, second request is ignored, busy falls after DONE.
